// File: rtl/s2p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s2p_pkg
// Purpose  : Shared definitions for the four-lane serial-to-parallel
//            converter with comma alignment (s2p_cond).
//            - Byte width, lane count, bit-counter width
//            - Default alignment (comma) symbol
//            - FSM state encoding (HUNT = 0, LOCKED = 1)
//            - Byte-slot classification helper used at each byte boundary
// Revision : 1.0 - initial release
// ============================================================================
package s2p_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned CTR_W     = $clog2(BYTE_W);

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  // Counter value of the slot holding the last (LSB) bit of a byte.
  localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(BYTE_W - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Outcome of a completed byte slot while locked.
  typedef enum logic [1:0] {
    SLOT_ALL_COMMA  = 2'd0,  // every lane carries the comma: re-alignment marker
    SLOT_DATA       = 2'd1,  // no lane carries the comma: regular data byte
    SLOT_MISALIGNED = 2'd2   // some but not all lanes carry it: lanes skewed
  } slot_e;

  // Classify a byte slot from the per-lane "candidate equals comma" flags.
  function automatic slot_e classify_slot(input logic [NUM_LANES-1:0] hits);
    slot_e res;
    if (&hits) begin
      res = SLOT_ALL_COMMA;
    end else if (hits == '0) begin
      res = SLOT_DATA;
    end else begin
      res = SLOT_MISALIGNED;
    end
    return res;
  endfunction

endpackage : s2p_pkg
`default_nettype wire

// File: rtl/shift_reg_s2p_cond.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_s2p_cond
// Purpose  : One lane of the serial front end. An 8-bit shift register that
//            takes one bit per enabled clock, MSB first, and presents the
//            byte that would result from accepting the current bit
//            (the "candidate") combinationally.
// Ports    : clk_i   - bit clock, rising edge
//            rst_ni  - asynchronous active-low reset, clears the register
//            en_i    - bit enable, register frozen while low
//            bit_i   - serial input bit for this lane
//            cand_o  - {register[6:0], bit_i}: byte completed by this bit
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_s2p_cond
  import s2p_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [BYTE_W-1:0] cand_o
);

  logic [BYTE_W-1:0] sr_q;
  logic [BYTE_W-1:0] sr_d;
  // The oldest bit falls off the end on the next shift and is never looked
  // at; it is kept so the register is a full byte as seen from outside.
  logic              unused_msb;

  assign sr_d       = {sr_q[BYTE_W-2:0], bit_i};
  assign cand_o     = sr_d;
  assign unused_msb = sr_q[BYTE_W-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= sr_d;
    end
  end

endmodule : shift_reg_s2p_cond
`default_nettype wire

// File: rtl/s2p_cond.sv
`default_nettype none
// ============================================================================
// Module   : s2p_cond
// Purpose  : Four-lane serial-to-parallel converter with comma alignment.
//            Each lane shifts in one bit per enabled clock (MSB first). In
//            HUNT the block searches bit by bit for the comma on all lanes
//            at once; once found it is LOCKED and counts bit slots. At
//            each byte boundary the completed bytes are delivered (no lane
//            is a comma), silently accepted as a re-alignment marker (all
//            lanes are commas), or flagged as lane misalignment (some
//            lanes are commas), which drops back to HUNT.
// Ports    : IN_CLK_s2p      - bit clock, all state on rising edge
//            IN_RESET_s2p    - asynchronous active-low reset
//            IN_ENB_s2p      - bit enable (low = no bit this cycle)
//            IN_LANE_s2p     - serial bits, bit n = lane n
//            OUT_LANE3..0_s2p- recovered data bytes, held between updates
//            OUT_VALID_s2p   - one-cycle pulse, new data bytes present
//            OUT_SYNC_s2p    - high while LOCKED
//            OUT_ERR_s2p     - one-cycle pulse on lane misalignment
//            OUT_CTR_s2p     - current bit index within the byte
// Revision : 1.0 - initial release
// ============================================================================
module s2p_cond
  import s2p_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
  input  logic                 IN_CLK_s2p,
  input  logic                 IN_RESET_s2p,
  input  logic                 IN_ENB_s2p,
  input  logic [NUM_LANES-1:0] IN_LANE_s2p,
  output logic [BYTE_W-1:0]    OUT_LANE3_s2p,
  output logic [BYTE_W-1:0]    OUT_LANE2_s2p,
  output logic [BYTE_W-1:0]    OUT_LANE1_s2p,
  output logic [BYTE_W-1:0]    OUT_LANE0_s2p,
  output logic                 OUT_VALID_s2p,
  output logic                 OUT_SYNC_s2p,
  output logic                 OUT_ERR_s2p,
  output logic [CTR_W-1:0]     OUT_CTR_s2p
);

  // --------------------------------------------------------------------------
  // Per-lane shift registers and comma comparators
  // --------------------------------------------------------------------------
  logic [BYTE_W-1:0]    cand      [NUM_LANES];
  logic [NUM_LANES-1:0] comma_hit;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    shift_reg_s2p_cond u_shift_reg (
      .clk_i  (IN_CLK_s2p),
      .rst_ni (IN_RESET_s2p),
      .en_i   (IN_ENB_s2p),
      .bit_i  (IN_LANE_s2p[n]),
      .cand_o (cand[n])
    );

    // Compared against the candidate, not the stored register, so the
    // decision is made on the same edge that accepts the byte's last bit.
    assign comma_hit[n] = (cand[n] == COMMA);
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [CTR_W-1:0]  ctr_q;
  logic [CTR_W-1:0]  ctr_d;
  logic [BYTE_W-1:0] data_q [NUM_LANES];
  logic              valid_q;
  logic              err_q;
  slot_e             slot;

  assign ctr_d = (ctr_q == LAST_BIT) ? '0 : ctr_q + 1'b1;
  assign slot  = classify_slot(comma_hit);

  always_ff @(posedge IN_CLK_s2p or negedge IN_RESET_s2p) begin
    if (!IN_RESET_s2p) begin
      state_q <= HUNT;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int n = 0; n < NUM_LANES; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      // Pulses last one cycle; a disabled edge always clears them.
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (IN_ENB_s2p) begin
        case (state_q)
          HUNT: begin
            // Bit-granular search: every enabled edge is a potential
            // byte boundary until the comma shows up on all lanes.
            ctr_q <= '0;
            if (&comma_hit) begin
              state_q <= LOCKED;
            end
          end

          LOCKED: begin
            ctr_q <= ctr_d;
            if (ctr_q == LAST_BIT) begin
              case (slot)
                SLOT_DATA: begin
                  valid_q <= 1'b1;
                  for (int n = 0; n < NUM_LANES; n++) begin
                    data_q[n] <= cand[n];
                  end
                end
                SLOT_MISALIGNED: begin
                  state_q <= HUNT;
                  err_q   <= 1'b1;
                end
                default: begin
                  // All-comma slot: alignment confirmed, nothing to deliver.
                end
              endcase
            end
          end

          default: begin
            state_q <= HUNT;
            ctr_q   <= '0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign OUT_LANE3_s2p = data_q[3];
  assign OUT_LANE2_s2p = data_q[2];
  assign OUT_LANE1_s2p = data_q[1];
  assign OUT_LANE0_s2p = data_q[0];
  assign OUT_VALID_s2p = valid_q;
  assign OUT_ERR_s2p   = err_q;
  assign OUT_SYNC_s2p  = (state_q == LOCKED);
  assign OUT_CTR_s2p   = ctr_q;

endmodule : s2p_cond
`default_nettype wire

// File: tb/tb_s2p_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p_cond
// Purpose  : Self-checking bench for s2p_cond. A byte-level vector table, a
//            few hand-written multi-cycle sequences (bit-offset lock, enable
//            stall, mid-byte reset) and a randomized phase compared against
//            a behavioural model built from the alignment rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2p_cond;

  localparam logic [7:0] COMMA_V = 8'hBC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] lanes;
  logic [7:0] o3, o2, o1, o0;
  logic       valid, sync, err;
  logic [2:0] ctr;

  always #5 clk = ~clk;

  s2p_cond #(.COMMA(COMMA_V)) dut (
    .IN_CLK_s2p    (clk),
    .IN_RESET_s2p  (rst_n),
    .IN_ENB_s2p    (en),
    .IN_LANE_s2p   (lanes),
    .OUT_LANE3_s2p (o3),
    .OUT_LANE2_s2p (o2),
    .OUT_LANE1_s2p (o1),
    .OUT_LANE0_s2p (o0),
    .OUT_VALID_s2p (valid),
    .OUT_SYNC_s2p  (sync),
    .OUT_ERR_s2p   (err),
    .OUT_CTR_s2p   (ctr)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: per-lane history of the last 8 bits as an integer,
  // a locked flag and the number of bits received since the last boundary.
  // --------------------------------------------------------------------------
  int m_hist   [4];
  int m_data   [4];
  bit m_locked;
  int m_pos;
  bit m_valid;
  bit m_err;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_hist[n] = 0;
      m_data[n] = 0;
    end
    m_locked = 0;
    m_pos    = 0;
    m_valid  = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] b);
    int hits;
    m_valid = 0;
    m_err   = 0;
    if (e) begin
      hits = 0;
      for (int n = 0; n < 4; n++) begin
        m_hist[n] = (m_hist[n] * 2 + int'(b[n])) % 256;
        if (m_hist[n] == int'(COMMA_V)) hits++;
      end
      if (!m_locked) begin
        if (hits == 4) begin
          m_locked = 1;
          m_pos    = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == 8) begin
          m_pos = 0;
          if (hits == 0) begin
            for (int n = 0; n < 4; n++) m_data[n] = m_hist[n];
            m_valid = 1;
          end else if (hits < 4) begin
            m_locked = 0;
            m_err    = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {24'h0, o3, o2, o1, o0, valid, err, sync, ctr};
  endfunction

  function automatic logic [63:0] model_vec();
    logic [2:0] c;
    c = m_locked ? 3'(m_pos) : 3'd0;
    return {24'h0, 8'(m_data[3]), 8'(m_data[2]), 8'(m_data[1]), 8'(m_data[0]),
            m_valid, m_err, m_locked, c};
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step(input logic e, input logic [3:0] b);
    @(negedge clk);
    en    = e;
    lanes = b;
    @(posedge clk);
    model_step(e, b);
    #1;
  endtask

  function automatic logic [3:0] bit_slice(input logic [31:0] bytes, input int i);
    logic [3:0] b;
    for (int n = 0; n < 4; n++) b[n] = bytes[8*n + 7 - i];
    return b;
  endfunction

  task automatic send_bits(input logic [31:0] bytes, input int first, input int count);
    for (int i = first; i < first + count; i++) step(1'b1, bit_slice(bytes, i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    lanes = 4'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Vector table: one record per byte slot
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] bytes;     // {lane3, lane2, lane1, lane0}
    logic        exp_valid;
    logic        exp_err;
    logic        exp_sync;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic        row_locked;
    logic [2:0]  exp_ctr;
    logic [7:0]  bc;
    int          kind;
    logic [31:0] bytes;

    rst_n = 1'b0;
    en    = 1'b0;
    lanes = 4'h0;
    model_reset();

    tbl[0] = '{32'hBCBCBCBC, 1'b0, 1'b0, 1'b1, 32'h00000000};
    tbl[1] = '{32'h12345678, 1'b1, 1'b0, 1'b1, 32'h12345678};
    tbl[2] = '{32'hBCBCBCBC, 1'b0, 1'b0, 1'b1, 32'h12345678};
    tbl[3] = '{32'hBCBCBCBC, 1'b0, 1'b0, 1'b1, 32'h12345678};
    tbl[4] = '{32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA};
    tbl[5] = '{32'h000000BC, 1'b0, 1'b1, 1'b0, 32'hAAAAAAAA};
    tbl[6] = '{32'hBCBCBCBC, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA};
    tbl[7] = '{32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A};

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    check("reset_state", dut_vec(), 64'h0);

    // ---------------- table-driven byte slots ----------------
    do_reset();
    row_locked = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 7; i++) begin
        step(1'b1, bit_slice(tbl[r].bytes, i));
        exp_ctr = row_locked ? 3'(i + 1) : 3'd0;
        check("tbl_mid_bit", {59'h0, valid, err, ctr}, {59'h0, 2'b00, exp_ctr});
      end
      step(1'b1, bit_slice(tbl[r].bytes, 7));
      check("tbl_boundary", {o3, o2, o1, o0, valid, err, sync, ctr},
            {tbl[r].exp_data, tbl[r].exp_valid, tbl[r].exp_err, tbl[r].exp_sync, 3'd0});
      row_locked = tbl[r].exp_sync;
    end

    // ---------------- comma at a 3-bit offset, release used at once ----------
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    lanes = 4'h0;
    model_reset();
    #1;
    check("async_reset_clears", dut_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    lanes = 4'hF;              // first garbage bit on the very first edge
    @(posedge clk);
    model_step(1'b1, 4'hF);
    #1;
    step(1'b1, 4'h0);
    step(1'b1, 4'hF);
    bc = COMMA_V;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {4{bc[7-i]}});
      if (i == 6) check("offset_no_early_lock", {63'h0, sync}, 64'h0);
    end
    check("offset_lock", {60'h0, sync, ctr}, {60'h0, 1'b1, 3'd0});
    send_bits(32'hAAAAAAAA, 0, 8);
    check("offset_data", {o3, o2, o1, o0, valid, err, sync},
          {32'hAAAAAAAA, 1'b1, 1'b0, 1'b1});

    // ---------------- enable stall mid-byte ----------------
    send_bits(32'h5A5A5A5A, 0, 4);
    check("stall_ctr_before", {61'h0, ctr}, 64'd4);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'($urandom));
      check("stall_frozen", {59'h0, valid, err, ctr}, {59'h0, 2'b00, 3'd4});
    end
    send_bits(32'h5A5A5A5A, 4, 3);
    check("stall_resume_ctr", {61'h0, ctr}, 64'd7);
    send_bits(32'h5A5A5A5A, 7, 1);
    check("stall_resume_data", {o3, o2, o1, o0, valid, err, sync},
          {32'h5A5A5A5A, 1'b1, 1'b0, 1'b1});
    step(1'b0, 4'h0);
    check("valid_drops_on_disabled", {62'h0, valid, err}, 64'h0);

    // ---------------- comma repeats: counter wrap, no valid ----------------
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bit_slice(32'hBCBCBCBC, i));
      check("comma_repeat", {58'h0, valid, err, sync, ctr},
            {58'h0, 2'b00, 1'b1, 3'((i + 1) % 8)});
    end

    // ---------------- reset at bit 5 of a data byte ----------------
    send_bits(32'h11223344, 0, 5);
    check("pre_reset", {o3, o2, o1, o0, sync, ctr}, {32'h5A5A5A5A, 1'b1, 3'd5});
    #2;
    rst_n = 1'b0;
    #1;
    check("midbyte_reset_outputs", dut_vec(), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, bit_slice((i < 8) ? 32'h12345678 : 32'h5A5A5A5A, i % 8));
      check("post_reset_no_valid", {59'h0, valid, sync, ctr}, 64'h0);
    end

    // ---------------- randomized stream vs model ----------------
    do_reset();
    repeat (350) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 2) begin
        bytes = 32'hBCBCBCBC;
      end else if (kind <= 7) begin
        bytes = $urandom;
      end else if (kind == 8) begin
        bytes = $urandom;
        for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 1) bytes[8*n +: 8] = COMMA_V;
      end else begin
        bytes = $urandom;
      end
      for (int i = 0; i < ((kind == 9) ? int'($urandom_range(1, 7)) : 8); i++) begin
        if ($urandom_range(0, 4) == 0) begin
          step(1'b0, 4'($urandom));
          check("rand_vs_model", dut_vec(), model_vec());
        end
        step(1'b1, bit_slice(bytes, i));
        check("rand_vs_model", dut_vec(), model_vec());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_s2p_cond
`default_nettype wire

// File: doc/s2p_cond.md
S2P_COND -- requirements
Module: s2p_cond

Interface
REQ-001 Parameter COMMA, default 8'hBC, alignment symbol expected simultaneously on all four lanes.
REQ-002 IN_CLK_s2p  input  1  serial bit clock; the block's only clock, all state on rising edge.
REQ-003 IN_RESET_s2p  input  1  reset, asynchronous, active-low.
REQ-004 IN_ENB_s2p  input  1  bit-enable; low = no bit this cycle.
REQ-005 IN_LANE_s2p  input  4  serial bits, bit n = lane n, MSB of each byte first.
REQ-006 OUT_LANE3_s2p..OUT_LANE0_s2p  output  8 each  recovered data bytes, one per lane.
REQ-007 OUT_VALID_s2p  output  1  one-cycle pulse, OUT_LANEx_s2p hold a new data byte.
REQ-008 OUT_SYNC_s2p  output  1  high while in LOCKED.
REQ-009 OUT_ERR_s2p  output  1  one-cycle pulse on lane misalignment detection.
REQ-010 OUT_CTR_s2p  output  3  current bit index within byte (0 = MSB slot).

Function
REQ-011 Per lane, an 8-bit shift register SHALL update to {sr[6:0], IN_LANE_s2p[n]} on every edge with IN_ENB_s2p high; no change when low.
REQ-012 Candidate byte per lane SHALL be {sr[6:0], incoming bit}, evaluated combinationally on enabled edges.
REQ-013 FSM states: HUNT (reset state), LOCKED.
REQ-014 HUNT: on an enabled edge where all four candidates equal COMMA -> LOCKED, bit counter := 0; otherwise stay, counter held at 0.
REQ-015 LOCKED: bit counter SHALL increment on each enabled edge, wrapping 7 -> 0.
REQ-016 LOCKED, enabled edge with counter = 7: all four candidates = COMMA -> stay, no output update, OUT_VALID_s2p low.
REQ-017 LOCKED, counter = 7, no candidate = COMMA -> OUT_LANEx_s2p := candidates on that edge, OUT_VALID_s2p high for exactly that following cycle.
REQ-018 LOCKED, counter = 7, 1-3 candidates = COMMA -> HUNT, OUT_ERR_s2p pulse one cycle, data outputs unchanged, no valid.
REQ-019 Latency: data byte visible, with OUT_VALID_s2p, in the cycle after the edge sampling its 8th bit.
REQ-020 OUT_VALID_s2p and OUT_ERR_s2p SHALL be low on every cycle following an edge with IN_ENB_s2p low.
REQ-021 Data outputs SHALL hold their last value between valid pulses.
REQ-022 IN_ENB_s2p low mid-byte SHALL freeze counter and shift registers; byte resumes at the same bit index.
REQ-023 Comma at arbitrary bit offset in HUNT SHALL be found (bit-granular search, no byte boundary assumed).

Reset
REQ-024 IN_RESET_s2p low SHALL immediately force: state HUNT, counter 0, shift registers 0, all OUT_LANEx_s2p 8'h00, OUT_VALID_s2p/OUT_SYNC_s2p/OUT_ERR_s2p 0, OUT_CTR_s2p 0.
REQ-025 Reset asserted mid-byte SHALL discard the partial byte; after release, alignment restarts from HUNT.
REQ-026 Release SHALL be consumed on the first rising edge after deassertion with no extra wait cycles.

Structure
REQ-027 COMMA default, state encodings (HUNT=0, LOCKED=1), and byte width 8 SHALL live in shared package s2p_pkg.
REQ-028 One sub-module, shift_reg_s2p_cond (8-bit enabled shift register), SHALL be instantiated four times; FSM, counter, output registers in s2p_cond.

Verification
REQ-029 Reset, then 8'hBC on all lanes, then bytes 12/34/56/78 (lanes 3..0) -> OUT_SYNC high after comma, one OUT_VALID pulse 8 enabled cycles later with OUT_LANE3..0 = 12/34/56/78.
REQ-030 HUNT with 3 garbage bits before comma -> lock on comma's 8th bit; next byte AA on all lanes recovered exactly.
REQ-031 LOCKED, byte slot with BC on lane 0 only, 00 elsewhere -> OUT_ERR pulse, OUT_SYNC low, no OUT_VALID, outputs unchanged.
REQ-032 LOCKED, IN_ENB low 5 cycles after bit 3 of byte 5A -> OUT_CTR frozen at 4, no pulses; resume -> 5A delivered with valid.
REQ-033 LOCKED, repeated comma bytes -> no OUT_VALID, OUT_SYNC stays high, OUT_CTR wraps 7 -> 0.
REQ-034 Reset asserted at bit 5 of a data byte -> all outputs 0 asynchronously; post-release data without comma -> no OUT_VALID.
